// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
//
// Expands a single LDM/STM instruction into a sequence of one-per-cycle
// transfers between the register bank and data memory. While the list is
// being walked, busy stalls fetch/decode; a one-cycle done pulse marks the end.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 launch request (only looked at in IDLE)
//   is_load, up, wback    LDM/STM, increment-after/decrement-before, writeback
//   rn, base              base register index and its current value
//   reg_list              16-bit register list, bit i selects Ri
//   mem_rd                memory read data for mem_addr (combinational)
//   rf_rd1                bank read data for rf_a1 (combinational)
//   mem_addr/we/wd        data memory port
//   rf_a1                 bank read address used by STM
//   rf_we3/a3/wd3         bank write port (R0-R14, and the Rn writeback)
//   pc_we/pc_wd           PC load for LDM that includes R15
//   busy, done            sequence status

module ldm_stm_sequencer #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_load,
  input  logic         up,
  input  logic         wback,
  input  logic [N-1:0] rn,
  input  logic [M-1:0] base,
  input  logic [15:0]  reg_list,
  input  logic [M-1:0] mem_rd,
  input  logic [M-1:0] rf_rd1,
  output logic [M-1:0] mem_addr,
  output logic         mem_we,
  output logic [M-1:0] mem_wd,
  output logic [N-1:0] rf_a1,
  output logic         rf_we3,
  output logic [N-1:0] rf_a3,
  output logic [M-1:0] rf_wd3,
  output logic         pc_we,
  output logic [M-1:0] pc_wd,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t       state;
  logic         ld_r;
  logic         wb_r;
  logic         rn_hit;
  logic [N-1:0] rn_r;
  logic [15:0]  list_r;
  logic [M-1:0] addr_r;
  logic [M-1:0] final_r;

  logic [4:0]   cnt;
  logic [M-1:0] span;
  logic [3:0]   idx;
  logic [15:0]  rest;

  // Block size in bytes (4 per listed register) of the incoming list.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, reg_list[i]};
    end
    span = M'({cnt, 2'b00});
  end

  // Lowest set bit of the remaining list is the register moved this cycle;
  // scanning downward lets the lowest index be the last assignment.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_r[i]) idx = 4'(i);
    end
    rest = list_r & (list_r - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ld_r    <= 1'b0;
      wb_r    <= 1'b0;
      rn_hit  <= 1'b0;
      rn_r    <= '0;
      list_r  <= '0;
      addr_r  <= '0;
      final_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ld_r    <= is_load;
            wb_r    <= wback;
            rn_r    <= rn;
            rn_hit  <= reg_list[rn];
            list_r  <= reg_list;
            // Decrement-before starts at the bottom of the block and still
            // walks upward, so both modes share the +4 step below.
            addr_r  <= up ? base : base - span;
            final_r <= up ? base + span : base - span;
            state   <= (reg_list != 16'd0) ? XFER : DONE;
          end
        end
        XFER: begin
          list_r <= rest;
          addr_r <= addr_r + M'(4);
          if (rest == 16'd0) begin
            // A load that includes Rn keeps the loaded value, not the address.
            state <= (wb_r && !(ld_r && rn_hit)) ? WB : DONE;
          end
        end
        WB:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; only the memory/bank read data
  // pass straight through.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    rf_a1    = '0;
    rf_we3   = 1'b0;
    rf_a3    = '0;
    rf_wd3   = '0;
    pc_we    = 1'b0;
    pc_wd    = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      XFER: begin
        busy     = 1'b1;
        mem_addr = addr_r;
        if (ld_r) begin
          if (idx == 4'd15) begin
            pc_we = 1'b1;
            pc_wd = mem_rd;
          end else begin
            rf_we3 = 1'b1;
            rf_a3  = N'(idx);
            rf_wd3 = mem_rd;
          end
        end else begin
          rf_a1  = N'(idx);
          mem_we = 1'b1;
          mem_wd = rf_rd1;
        end
      end
      WB: begin
        busy   = 1'b1;
        rf_we3 = 1'b1;
        rf_a3  = rn_r;
        rf_wd3 = final_r;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-register transfer sequencer for the ARM datapath. It expands one LDM/STM instruction into one register-file or memory transfer per cycle. It is the write-side driver of the register bank: LDM writes loaded words through the bank write port (A3/WE3/WD3), and STM reads registers through a bank read port. It sits beside the data memory and stalls the fetch/decode path via `busy` until the transfer list is exhausted.

## Interface
- N, 4, register address width
- M, 32, data/address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- up  in  1  1 = increment-after, 0 = decrement-before
- wback  in  1  write final address back to Rn
- rn  in  N  base register index
- base  in  M  base address (value of Rn)
- reg_list  in  16  register list, bit i = Ri
- mem_rd  in  M  data memory read data (combinational, same cycle as mem_addr)
- rf_rd1  in  M  bank read data for rf_a1 (R15 supplied by bank)
- mem_addr  out  M  data memory address
- mem_we  out  1  data memory write enable
- mem_wd  out  M  data memory write data
- rf_a1  out  N  bank read address (STM)
- rf_we3  out  1  bank write enable (R0–R14 only)
- rf_a3  out  N  bank write address
- rf_wd3  out  M  bank write data
- pc_we  out  1  PC load enable (LDM with bit 15)
- pc_wd  out  M  PC load value
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE: on start=1, latch is_load, up, wback, rn, reg_list (remaining list), count = popcount(reg_list).
  - Start address: up ? base : base − 4·count; final address: up ? base + 4·count : base − 4·count (mod 2^M).
  - Nonzero list → XFER; zero list → DONE (no transfers, no writeback).
- XFER, one register per cycle, ascending index order: idx = lowest set bit of the remaining list; mem_addr = current address.
  - Load: mem_we=0.
    - idx<15: rf_we3=1, rf_a3=idx, rf_wd3=mem_rd.
    - idx=15: pc_we=1, pc_wd=mem_rd, rf_we3=0.
  - Store: rf_a1=idx, mem_we=1, mem_wd=rf_rd1.
  - On the clock edge: clear bit idx; address += 4.
  - When the last bit is cleared: go to WB if wback, unless (is_load and reg_list[rn]), in which case the loaded value wins and the state goes to DONE. Otherwise go to DONE.
- WB: rf_we3=1, rf_a3=rn, rf_wd3=final address; → DONE.
- DONE: done=1; → IDLE.
- busy=1 in XFER and WB; 0 in IDLE and DONE.
- start is ignored outside IDLE.
- All enables and data outputs not named above are 0 in the current state.
- Address arithmetic is M-bit and wraps modulo 2^M; no alignment checks.

## Timing
- Reset: state=IDLE and remaining list cleared. All outputs 0: mem_we, rf_we3, pc_we, busy, done, mem_addr, mem_wd, rf_a1, rf_a3, rf_wd3, pc_wd.
- Reset asserted mid-sequence: no write enable is asserted in any cycle after the reset edge. Partially completed transfers are not undone.
- Outputs are decoded from registered state, with the combinational data paths mem_rd→rf_wd3/pc_wd and rf_rd1→mem_wd.
- start accepted in cycle 0. Transfer k (1..n) occurs in cycle k. WB occurs in cycle n+1 if taken. done is asserted in cycle n+1 (no WB) or n+2 (WB). For an empty list, done is asserted in cycle 1.
- Back-to-back: start is accepted again in the cycle after done.

## Test plan
- LDM IA, base=0x100, list=0x000B, rn=4, wback=1, mem[0x100/0x104/0x108]=A/B/C → cycles 1–3 write R0=A, R1=B, R3=C; cycle 4 writes R4=0x10C; done in cycle 5; busy high in cycles 1–4.
- STM DB, base=0x200, list=0x8001, wback=1, rn=13 → cycle 1: mem[0x1F8]=R0; cycle 2: mem[0x1FC]=R15 (via rf_a1=15); cycle 3: R13=0x1F8; done in cycle 4.
- LDM IA, list=0x0004, rn=2, wback=1 → R2 is loaded from memory in cycle 1; no writeback; done in cycle 2.
- LDM IA, list=0x8000 → cycle 1: pc_we=1 with pc_wd=mem_rd and rf_we3=0; done in cycle 2.
- Empty list with start=1 → no mem_we/rf_we3/pc_we; done in cycle 1. Also, start pulsed while busy is ignored.
- Reset in cycle 2 of a 4-register LDM → from the next cycle, all enables are 0, state is IDLE, and no done pulse occurs. A new start then runs normally.
